multi_digit_led_scanner: RTL and testbench

//  Parametrised time-multiplexed driver for an N-digit common-anode 7-segment display.
//  - Scans digits with a programmable on-time and a blanking gap to suppress ghosting.
//  - Per-digit decimal points; optional leading-zero suppression.
//  - Snapshots the display word once per frame, so a digit never changes mid-scan.
//  - Sits between the receiver datapath (hex word source) and the board pins.

---
 rtl/led_display_pkg.sv | 53 +++++
 rtl/seg7_hex_decoder.sv | 11 +
 rtl/multi_digit_led_scanner.sv | 141 ++++++++++++++
 tb/tb_multi_digit_led_scanner.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_display_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: active-low glyphs,
// scan state type and the hex-to-segment decode used by the digit decoder.
package led_display_pkg;

    // Segment order is {a,b,c,d,e,f,g}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h01;
    localparam logic [6:0] SEG_1     = 7'h4F;
    localparam logic [6:0] SEG_2     = 7'h12;
    localparam logic [6:0] SEG_3     = 7'h06;
    localparam logic [6:0] SEG_4     = 7'h4C;
    localparam logic [6:0] SEG_5     = 7'h24;
    localparam logic [6:0] SEG_6     = 7'h20;
    localparam logic [6:0] SEG_7     = 7'h0F;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h04;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h60;
    localparam logic [6:0] SEG_C     = 7'h31;
    localparam logic [6:0] SEG_D     = 7'h42;
    localparam logic [6:0] SEG_E     = 7'h30;
    localparam logic [6:0] SEG_F     = 7'h38;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
        logic [6:0] glyph;
        glyph = SEG_BLANK;
        case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            4'hF: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment glyph.
module seg7_hex_decoder
    import led_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = hex_to_seg7(nibble);

endmodule

// File: rtl/multi_digit_led_scanner.sv
// Time-multiplexed N-digit common-anode 7-segment driver with blanking gaps,
// per-frame snapshot of the display word and optional leading-zero suppression.
//
//   state | meaning
//   BLANK | all anodes off for BLANK_CYCLES before the digit at idx
//   ON    | anode idx lit for ON_CYCLES with the snapshot glyph
module multi_digit_led_scanner
    import led_display_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int ON_CYCLES    = 1000,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_SUPPRESS  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_mask,
    output logic [N_DIGITS-1:0]   an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_done
);

    localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(N_DIGITS - 1);

    scan_state_t           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] snap_q, snap_d;
    logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic                  frame_start;
    logic [3:0]            digit_nibble;
    logic [6:0]            digit_glyph;
    logic [N_DIGITS-1:0]   lead_zero;
    logic                  lz_blank;

    assign frame_start = (state_q == BLANK) && (idx_q == IDX_TOP) && (cnt_q == '0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        snap_dp_d = snap_dp_q;

        if (!en || frame_start) begin
            snap_d    = value;
            snap_dp_d = dp_mask;
        end

        if (!en) begin
            state_d = BLANK;
            idx_d   = IDX_TOP;
            cnt_d   = '0;
        end else begin
            case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        idx_d   = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next-state view so pins and state move together.
    assign digit_nibble = snap_d[{idx_d, 2'b00} +: 4];

    seg7_hex_decoder u_decoder (
        .nibble (digit_nibble),
        .seg    (digit_glyph)
    );

    // lead_zero[k]: nibbles k..N_DIGITS-1 of the upcoming snapshot are all zero.
    always_comb begin
        logic run_zero;
        run_zero  = 1'b1;
        lead_zero = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            run_zero     = run_zero && (snap_d[4*k +: 4] == 4'h0);
            lead_zero[k] = run_zero;
        end
    end

    assign lz_blank = (LZ_SUPPRESS != 0) && (idx_d != '0) && lead_zero[idx_d];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BLANK;
            idx_q      <= IDX_TOP;
            cnt_q      <= '0;
            snap_q     <= '0;
            snap_dp_q  <= '0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            snap_dp_q <= snap_dp_d;
            if (state_d == ON) begin
                an  <= ~(N_DIGITS'(1) << idx_d);
                seg <= lz_blank ? SEG_BLANK : digit_glyph;
                dp  <= ~snap_dp_d[idx_d];
            end else begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end
            frame_done <= (state_d == ON) && (idx_d == '0) && (cnt_d == ON_LAST);
        end
    end

endmodule

// File: tb/tb_multi_digit_led_scanner.sv
// Bench for multi_digit_led_scanner: directed vector tables plus random stimulus
// against a frame-position reference model, with and without zero suppression.
module tb_multi_digit_led_scanner;

    localparam int N     = 4;
    localparam int ON_C  = 4;
    localparam int BL_C  = 2;
    localparam int SLOT  = ON_C + BL_C;
    localparam int FRAME = N * SLOT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_mask = 4'h0;

    logic [3:0] an0, an1;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1, fd0, fd1;

    multi_digit_led_scanner #(
        .N_DIGITS(N), .ON_CYCLES(ON_C), .BLANK_CYCLES(BL_C), .LZ_SUPPRESS(0)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .value(value), .dp_mask(dp_mask),
        .an(an0), .seg(seg0), .dp(dp0), .frame_done(fd0)
    );

    multi_digit_led_scanner #(
        .N_DIGITS(N), .ON_CYCLES(ON_C), .BLANK_CYCLES(BL_C), .LZ_SUPPRESS(1)
    ) dut_lz (
        .clk(clk), .reset(reset), .en(en), .value(value), .dp_mask(dp_mask),
        .an(an1), .seg(seg1), .dp(dp1), .frame_done(fd1)
    );

    always #5 clk = ~clk;

    // Reference model: position within the frame and the word latched for it.
    int          m_p = 0;
    int          m_stable = 0;
    logic [15:0] m_snap = 16'h0;
    logic [3:0]  m_dpm = 4'h0;

    always @(posedge clk) begin
        if (reset || !en) begin
            m_p      <= 0;
            m_stable <= 0;
            m_snap   <= reset ? 16'h0 : value;
            m_dpm    <= reset ? 4'h0 : dp_mask;
        end else begin
            if (m_p == 0) begin
                m_snap <= value;
                m_dpm  <= dp_mask;
            end
            m_p      <= (m_p + 1) % FRAME;
            m_stable <= m_stable + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int cycle_no = 0;
    int prev_fd = 0;
    bit have_fd = 1'b0;

    typedef struct {
        int         phase;
        int         lz;
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } vec_t;

    vec_t vecs[$];

    logic [3:0] l_an [2][80];
    logic [6:0] l_seg[2][80];
    logic       l_dp [2][80];
    logic       l_fd [2][80];

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] lit;
        case (h)
            4'h0: lit = 7'b1111110;
            4'h1: lit = 7'b0110000;
            4'h2: lit = 7'b1101101;
            4'h3: lit = 7'b1111001;
            4'h4: lit = 7'b0110011;
            4'h5: lit = 7'b1011011;
            4'h6: lit = 7'b1011111;
            4'h7: lit = 7'b1110000;
            4'h8: lit = 7'b1111111;
            4'h9: lit = 7'b1111011;
            4'hA: lit = 7'b1110111;
            4'hB: lit = 7'b0011111;
            4'hC: lit = 7'b1001110;
            4'hD: lit = 7'b0111101;
            4'hE: lit = 7'b1001111;
            default: lit = 7'b1000111;
        endcase
        return ~lit;
    endfunction

    function automatic void expect_out(input int p, input logic [15:0] snap,
                                       input logic [3:0] dpm, input bit lz,
                                       output logic [3:0] e_an, output logic [6:0] e_seg,
                                       output logic e_dp, output logic e_fd);
        int d;
        logic [15:0] upper;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fd  = (p == FRAME - 1);
        if ((p % SLOT) >= BL_C) begin
            d     = N - 1 - p / SLOT;
            upper = snap >> (4 * d);
            e_an  = ~(4'b0001 << d);
            e_seg = (lz && d > 0 && upper == 16'h0) ? 7'h7F : glyph(upper[3:0]);
            e_dp  = ~dpm[d];
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp, e_fd;
        cycle_no++;
        expect_out(m_p, m_snap, m_dpm, 1'b0, e_an, e_seg, e_dp, e_fd);
        check("mdl_an", 32'(an0), 32'(e_an));
        check("mdl_seg", 32'(seg0), 32'(e_seg));
        check("mdl_dp", 32'(dp0), 32'(e_dp));
        check("mdl_fd", 32'(fd0), 32'(e_fd));
        expect_out(m_p, m_snap, m_dpm, 1'b1, e_an, e_seg, e_dp, e_fd);
        check("mdl_lz_an", 32'(an1), 32'(e_an));
        check("mdl_lz_seg", 32'(seg1), 32'(e_seg));
        check("mdl_lz_dp", 32'(dp1), 32'(e_dp));
        check("mdl_lz_fd", 32'(fd1), 32'(e_fd));
        check("one_anode", 32'($countones(~an0) <= 1), 32'd1);
        if (fd0 === 1'b1) begin
            if (have_fd && m_stable >= cycle_no - prev_fd)
                check("fd_period", 32'(cycle_no - prev_fd), 32'(FRAME));
            have_fd = 1'b1;
            prev_fd = cycle_no;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    function automatic void add(input int ph, input int lz, input int cyc, input logic [3:0] a,
                                input logic [6:0] s, input logic d, input logic f);
        vec_t v;
        v.phase = ph; v.lz = lz; v.cyc = cyc; v.an = a; v.seg = s; v.dp = d; v.fd = f;
        vecs.push_back(v);
    endfunction

    // Starts on the negedge of cycle 0 after reset release.
    task automatic run_phase(input int phase, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) tick();
            l_an[0][c] = an0;  l_seg[0][c] = seg0;  l_dp[0][c] = dp0;  l_fd[0][c] = fd0;
            l_an[1][c] = an1;  l_seg[1][c] = seg1;  l_dp[1][c] = dp1;  l_fd[1][c] = fd1;
            case (phase)
                1: if (c == 34) value = 16'h3456;
                5: begin
                    if (c == 8)  en = 1'b0;
                    if (c == 13) en = 1'b1;
                end
                6: begin
                    if (c == 15) reset = 1'b1;
                    if (c == 16) reset = 1'b0;
                end
                default: ;
            endcase
        end
        foreach (vecs[i]) begin
            if (vecs[i].phase == phase) begin
                check($sformatf("p%0d_lz%0d_c%0d_an", phase, vecs[i].lz, vecs[i].cyc),
                      32'(l_an[vecs[i].lz][vecs[i].cyc]), 32'(vecs[i].an));
                check($sformatf("p%0d_lz%0d_c%0d_seg", phase, vecs[i].lz, vecs[i].cyc),
                      32'(l_seg[vecs[i].lz][vecs[i].cyc]), 32'(vecs[i].seg));
                check($sformatf("p%0d_lz%0d_c%0d_dp", phase, vecs[i].lz, vecs[i].cyc),
                      32'(l_dp[vecs[i].lz][vecs[i].cyc]), 32'(vecs[i].dp));
                check($sformatf("p%0d_lz%0d_c%0d_fd", phase, vecs[i].lz, vecs[i].cyc),
                      32'(l_fd[vecs[i].lz][vecs[i].cyc]), 32'(vecs[i].fd));
            end
        end
    endtask

    initial begin
        // Phase 1: 12AF after reset, word changes to 3456 at cycle 10 of the second frame.
        add(1, 0, 0,  4'hF, 7'h7F, 1, 0);   add(1, 0, 1,  4'hF, 7'h7F, 1, 0);
        add(1, 0, 2,  4'h7, glyph(4'h1), 1, 0);   add(1, 0, 5,  4'h7, glyph(4'h1), 1, 0);
        add(1, 0, 6,  4'hF, 7'h7F, 1, 0);   add(1, 0, 8,  4'hB, glyph(4'h2), 1, 0);
        add(1, 0, 14, 4'hD, glyph(4'hA), 1, 0);   add(1, 0, 20, 4'hE, glyph(4'hF), 1, 0);
        add(1, 0, 23, 4'hE, glyph(4'hF), 1, 1);   add(1, 0, 24, 4'hF, 7'h7F, 1, 0);
        add(1, 0, 38, 4'hD, glyph(4'hA), 1, 0);   add(1, 0, 44, 4'hE, glyph(4'hF), 1, 0);
        add(1, 0, 47, 4'hE, glyph(4'hF), 1, 1);   add(1, 0, 50, 4'h7, glyph(4'h3), 1, 0);
        add(1, 0, 56, 4'hB, glyph(4'h4), 1, 0);   add(1, 0, 62, 4'hD, glyph(4'h5), 1, 0);
        add(1, 0, 68, 4'hE, glyph(4'h6), 1, 0);   add(1, 0, 71, 4'hE, glyph(4'h6), 1, 1);
        // Phase 3: 0070 with dp on digit 3.
        add(3, 1, 2,  4'h7, 7'h7F, 0, 0);   add(3, 1, 8,  4'hB, 7'h7F, 1, 0);
        add(3, 1, 14, 4'hD, glyph(4'h7), 1, 0);   add(3, 1, 20, 4'hE, glyph(4'h0), 1, 0);
        add(3, 0, 2,  4'h7, glyph(4'h0), 0, 0);
        // Phase 4: all-zero word.
        add(4, 1, 2,  4'h7, 7'h7F, 1, 0);   add(4, 1, 8,  4'hB, 7'h7F, 1, 0);
        add(4, 1, 14, 4'hD, 7'h7F, 1, 0);   add(4, 1, 20, 4'hE, glyph(4'h0), 1, 0);
        // Phase 5: en low for cycles 8..12.
        add(5, 0, 8,  4'hB, glyph(4'h2), 1, 0);   add(5, 0, 9,  4'hF, 7'h7F, 1, 0);
        add(5, 0, 12, 4'hF, 7'h7F, 1, 0);   add(5, 0, 14, 4'hF, 7'h7F, 1, 0);
        add(5, 0, 15, 4'h7, glyph(4'h1), 1, 0);   add(5, 0, 35, 4'hE, glyph(4'hF), 1, 0);
        add(5, 0, 36, 4'hE, glyph(4'hF), 1, 1);
        // Phase 6: reset during ON of digit 1.
        add(6, 0, 15, 4'hD, glyph(4'hA), 1, 0);   add(6, 0, 16, 4'hF, 7'h7F, 1, 0);
        add(6, 0, 17, 4'hF, 7'h7F, 1, 0);   add(6, 0, 18, 4'h7, glyph(4'h1), 1, 0);
        add(6, 0, 39, 4'hE, glyph(4'hF), 1, 1);

        en = 1'b1; value = 16'h12AF; dp_mask = 4'h0;
        do_reset(); run_phase(1, 72);

        value = 16'h0070; dp_mask = 4'b1000;
        do_reset(); run_phase(3, 24);

        value = 16'h0000; dp_mask = 4'h0;
        do_reset(); run_phase(4, 24);

        value = 16'h12AF;
        do_reset(); run_phase(5, 40);

        do_reset(); run_phase(6, 40);

        do_reset();
        for (int i = 0; i < 800; i++) begin
            tick();
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 4))
                    0: value = 16'($urandom);
                    1: value = 16'($urandom) & 16'h0FFF;
                    2: value = 16'($urandom) & 16'h00FF;
                    3: value = 16'($urandom) & 16'h000F;
                    default: value = 16'h0000;
                endcase
                dp_mask = 4'($urandom);
            end
            en    = ($urandom_range(0, 59) != 0);
            reset = ($urandom_range(0, 299) == 0);
        end
        reset = 1'b0;
        en    = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
